// File: rtl/regfile_wb_scheduler.sv
// Writeback arbiter for the register file's single write port. It round-robins between
// the ALU (A) and load (B) sources and keeps a busy scoreboard that stalls decode.
module regfile_wb_scheduler #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_wr,
    input  logic [AW-1:0]   rr1,
    input  logic [AW-1:0]   rr2,
    output logic            stall,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_wr,
    input  logic [DW-1:0]   a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [AW-1:0]   b_wr,
    input  logic [DW-1:0]   b_data,
    output logic            b_ready,
    output logic            regwrite,
    output logic [AW-1:0]   wr,
    output logic [DW-1:0]   write_data,
    output logic [NREG-1:0] busy
);

    logic            regwrite_reg;
    logic [AW-1:0]   wr_reg;
    logic [DW-1:0]   write_data_reg;
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic            last_grant_reg;   // 1 = B was granted last
    logic            grant_a;
    logic            grant_b;
    logic [AW-1:0]   sel_wr;
    logic [DW-1:0]   sel_data;
    logic            issue_en;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            if (a_valid && (!b_valid || last_grant_reg)) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign sel_wr   = grant_a ? a_wr   : b_wr;
    assign sel_data = grant_a ? a_data : b_data;

    assign stall    = reset | busy_reg[rr1] | busy_reg[rr2]
                    | (issue_valid & busy_reg[issue_wr]);
    assign issue_en = issue_valid & ~stall & (issue_wr != '0);

    // A new issue to the same index beats the clear of the older writer.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                assign busy_next[gi] =
                    (busy_reg[gi] & ~(regwrite_reg && (wr_reg == AW'(gi))))
                    | (issue_en && (issue_wr == AW'(gi)));
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            regwrite_reg   <= 1'b0;
            wr_reg         <= '0;
            write_data_reg <= '0;
            busy_reg       <= '0;
            last_grant_reg <= 1'b1;
        end else begin
            busy_reg <= busy_next;
            if (grant_a || grant_b) begin
                regwrite_reg   <= (sel_wr != '0);
                wr_reg         <= sel_wr;
                write_data_reg <= sel_data;
                last_grant_reg <= grant_b;
            end else begin
                regwrite_reg <= 1'b0;
            end
        end
    end

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign regwrite   = regwrite_reg;
    assign wr         = wr_reg;
    assign write_data = write_data_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: arbitration order, writeback latency,
// scoreboard set/clear, stall, and the zero-register and reset cases.
module tb_regfile_wb_scheduler;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            issue_valid;
    logic [AW-1:0]   issue_wr;
    logic [AW-1:0]   rr1;
    logic [AW-1:0]   rr2;
    logic            stall;
    logic            a_valid;
    logic [AW-1:0]   a_wr;
    logic [DW-1:0]   a_data;
    logic            a_ready;
    logic            b_valid;
    logic [AW-1:0]   b_wr;
    logic [DW-1:0]   b_data;
    logic            b_ready;
    logic            regwrite;
    logic [AW-1:0]   wr;
    logic [DW-1:0]   write_data;
    logic [NREG-1:0] busy;

    logic [DW-1:0]   rf [NREG];
    int              checks = 0;
    int              errors = 0;

    regfile_wb_scheduler #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_wr(issue_wr),
        .rr1(rr1), .rr2(rr2), .stall(stall),
        .a_valid(a_valid), .a_wr(a_wr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_wr(b_wr), .b_data(b_data), .b_ready(b_ready),
        .regwrite(regwrite), .wr(wr), .write_data(write_data), .busy(busy)
    );

    always #5 clock = ~clock;

    // Simple register file model so a read-back of a written register can be checked.
    always @(posedge clock) begin
        if (regwrite) rf[wr] <= write_data;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; issue_valid = 1'b0; issue_wr = '0; rr1 = '0; rr2 = '0;
        a_valid = 1'b1; a_wr = 5'd3; a_data = 32'd1;
        b_valid = 1'b1; b_wr = 5'd4; b_data = 32'd2;
        for (int i = 0; i < NREG; i++) rf[i] = '0;

        // 1. reset: grants blocked and stall forced while reset is high
        settle();
        check_val("rst_stall", stall, 1);
        check_val("rst_a_ready", a_ready, 0);
        check_val("rst_b_ready", b_ready, 0);
        for (int i = 0; i < 10; i++) tick();
        a_valid = 1'b0; b_valid = 1'b0; reset = 1'b0;
        settle();
        check_val("idle_stall", stall, 0);
        check_val("idle_regwrite", regwrite, 0);
        check_val("idle_busy", busy, 0);
        check_val("idle_a_ready", a_ready, 0);
        check_val("idle_b_ready", b_ready, 0);

        // 2. issue 16, write it back two cycles later
        issue_valid = 1'b1; issue_wr = 5'd16;
        tick();
        issue_valid = 1'b0;
        check_val("t2_busy_set", busy, 32'h0001_0000);
        tick();
        a_valid = 1'b1; a_wr = 5'd16; a_data = 32'd100;
        settle();
        check_val("t2_a_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        check_val("t2_regwrite", regwrite, 1);
        check_val("t2_wr", wr, 16);
        check_val("t2_data", write_data, 100);
        check_val("t2_busy_held", busy, 32'h0001_0000);
        tick();
        check_val("t2_regwrite_off", regwrite, 0);
        check_val("t2_busy_clr", busy, 0);
        rr1 = 5'd16;
        check_val("t2_rf16", rf[rr1], 100);
        rr1 = '0;

        // lone B writeback (non-busy register) so last_grant becomes B
        b_valid = 1'b1; b_wr = 5'd5; b_data = 32'd7;
        settle();
        check_val("lone_b_ready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        check_val("lone_b_wr", wr, 5);

        // 3. tie: A first (last grant was B), then B
        a_valid = 1'b1; a_wr = 5'd17; a_data = 32'd150;
        b_valid = 1'b1; b_wr = 5'd18; b_data = 32'd200;
        settle();
        check_val("t3_a_first", {a_ready, b_ready}, 2'b10);
        tick();
        a_valid = 1'b0;
        check_val("t3_wr_a", {wr, write_data}, {5'd17, 32'd150});
        check_val("t3_b_next", {a_ready, b_ready}, 2'b01);
        tick();
        b_valid = 1'b0;
        check_val("t3_wr_b", {regwrite, wr, write_data}, {1'b1, 5'd18, 32'd200});
        tick();
        check_val("t3_idle", regwrite, 0);

        // 4. continuous contention alternates A,B,A,B,A,B
        a_valid = 1'b1; a_wr = 5'd3; a_data = 32'd111;
        b_valid = 1'b1; b_wr = 5'd4; b_data = 32'd222;
        for (int i = 0; i < 6; i++) begin
            settle();
            check_val($sformatf("t4_grant%0d", i), {a_ready, b_ready},
                      (i % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            check_val($sformatf("t4_wb%0d", i), {regwrite, wr, write_data},
                      (i % 2 == 0) ? {1'b1, 5'd3, 32'd111} : {1'b1, 5'd4, 32'd222});
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();

        // 5. stall on a pending source; issue ignored while stalled
        issue_valid = 1'b1; issue_wr = 5'd17;
        tick();
        issue_valid = 1'b0;
        rr1 = 5'd17;
        settle();
        check_val("t5_stall", stall, 1);
        issue_valid = 1'b1; issue_wr = 5'd9;
        tick();
        issue_valid = 1'b0;
        check_val("t5_issue_ignored", busy, 32'h0002_0000);
        a_valid = 1'b1; a_wr = 5'd17; a_data = 32'd77;
        tick();
        a_valid = 1'b0;
        check_val("t5_stall_during_wb", {stall, regwrite, wr}, {1'b1, 1'b1, 5'd17});
        tick();
        check_val("t5_stall_drop", stall, 0);
        check_val("t5_busy_clr", busy, 0);
        // re-issue 17 on the very edge a second writeback to 17 lands: set wins
        rr1 = '0;
        a_valid = 1'b1; a_wr = 5'd17; a_data = 32'd88;
        tick();
        a_valid = 1'b0;
        issue_valid = 1'b1; issue_wr = 5'd17;
        settle();
        check_val("t5_issue_ok", {stall, regwrite, wr}, {1'b0, 1'b1, 5'd17});
        tick();
        issue_valid = 1'b0;
        check_val("t5_set_wins", busy, 32'h0002_0000);

        // 6. write to x0 handshakes but never writes; reset discards a pending write
        a_valid = 1'b1; a_wr = 5'd0; a_data = 32'd55;
        settle();
        check_val("t6_x0_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        check_val("t6_x0_regwrite", regwrite, 0);
        check_val("t6_x0_busy", busy, 32'h0002_0000);
        a_valid = 1'b1; a_wr = 5'd9; a_data = 32'd9;
        tick();
        a_valid = 1'b0;
        reset = 1'b1;
        settle();
        check_val("t6_rst_stall", stall, 1);
        tick();
        check_val("t6_rst_regwrite", regwrite, 0);
        check_val("t6_rst_busy", busy, 0);
        reset = 1'b0;
        tick();
        check_val("t6_after_rst", {stall, regwrite}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
Sequences the single write port of the 32x32 register file (regwrite/wr/write_data) between two writeback sources: A (ALU) and B (memory/load). Keeps a 32-entry busy scoreboard of issued but unwritten destinations. Raises a stall to decode while a source register or the new destination is still pending. Sits between the execute/memory stages and regfile.

Parameters:
NREG, 32, number of architectural registers (scoreboard width)
AW, 5, register index width
DW, 32, data width

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
issue_valid  in  1  decode issues an instruction with destination issue_wr
issue_wr  in  AW  destination index of issuing instruction
rr1  in  AW  decode source index 1
rr2  in  AW  decode source index 2
stall  out  1  decode must hold; issue_valid is ignored while high
a_valid  in  1  source A has a writeback
a_wr  in  AW  A destination index
a_data  in  DW  A write value
a_ready  out  1  A writeback accepted this cycle
b_valid  in  1  source B has a writeback
b_wr  in  AW  B destination index
b_data  in  DW  B write value
b_ready  out  1  B writeback accepted this cycle
regwrite  out  1  to regfile regwrite, registered
wr  out  AW  to regfile wr, registered
write_data  out  DW  to regfile write_data, registered
busy  out  NREG  scoreboard, bit r = write to r outstanding

Behaviour:
- Reset (reset=1 at an edge): regwrite=0, wr=0, write_data=0, busy=0, last_grant=B, so A wins the first tie. While reset is high, a_ready=b_ready=0 and stall=1.
- Arbitration is combinational, round-robin:
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the source not in last_grant.
  - a_ready/b_ready = grant, at most one high per cycle.
- A source holds valid/wr/data stable until ready. An ungranted source is never dropped.
- last_grant updates on every accepted handshake.
- Accept at edge N: regwrite=1, wr=x_wr, write_data=x_data during cycle N+1. With no accept at edge N, regwrite=0 in cycle N+1. wr/write_data hold their last values.
- Latency is 1 cycle from accept to regfile write. Throughput is 1 writeback per cycle, with no backpressure from the regfile.
- Register 0 is hardwired zero:
  - A writeback to index 0 completes its handshake, but regwrite stays 0 in the following cycle.
  - busy[0] is never set.
- Scoreboard:
  - Set: busy[issue_wr] is set at an edge where issue_valid=1, stall=0 and issue_wr!=0.
  - Clear: busy[wr] is cleared at the edge that ends a cycle with regwrite=1. This is the same edge at which the regfile captures the data.
  - Set and clear of the same index at one edge: set wins, because a newer writer is pending.
  - Writebacks to non-busy registers are legal and write normally.
- Stall is combinational:
  - stall = reset | busy[rr1] | busy[rr2] | (issue_valid & busy[issue_wr]).
  - The busy[0] term is always 0.
  - Stall drops in the cycle after regwrite for the awaited register. No bypass is provided.
- Reset mid-operation clears all pending state. An accepted writeback not yet driven on regwrite is discarded. A/B must re-present after reset falls.

Test Plan:
1. Reset for 10 cycles, then release -> regwrite=0, busy=0, stall=0, a_ready=b_ready=0 with no valids.
2. Issue dest 16, then a_valid with a_wr=16, a_data=100 two cycles later -> busy[16]=1 after the issue edge; a_ready=1 for 1 cycle; next cycle regwrite=1, wr=16, write_data=100; busy[16]=0 after that edge. Reading rr1=16 from the regfile returns 100.
3. a_valid (wr=17, data=150) and b_valid (wr=18, data=200) in the same cycle, both held -> A granted first, then B. regwrite shows 17/150, then 18/200 on consecutive cycles; a_ready and b_ready are never high together.
4. Continuous a_valid and b_valid for 6 cycles -> grants alternate A,B,A,B,A,B with no idle cycle.
5. busy[17]=1, rr1=17 -> stall=1 and issue_valid is ignored. Writeback for 17 lands -> stall=0 in the following cycle. Issue dest 17 at the same edge as the clear -> busy[17] stays 1.
6. a_valid with a_wr=0, a_data=55 -> a_ready=1, regwrite stays 0, busy unchanged. Assert reset the cycle after an accept to reg 9 -> regwrite=0 and busy=0 after the reset edge.
